// File: rtl/btn_pkg.sv
// Shared types and parameter defaults for the button filter array.
// Press FSM states plus the default configuration values used by the top.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } btn_state_e;

    localparam int BTN_N_CH_DEF         = 4;
    localparam int BTN_TICK_DIV_DEF     = 1000;
    localparam int BTN_STABLE_CNT_DEF   = 8;
    localparam int BTN_LONG_TICKS_DEF   = 50000;
    localparam int BTN_REPEAT_TICKS_DEF = 10000;

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchronizer, tick-sampled debounce, edge pulses, press FSM.
// Auto-repeat logic is present only when BTN_REPEAT_EN is defined.
module btn_channel
    import btn_pkg::*;
#(
    parameter int STABLE_CNT   = BTN_STABLE_CNT_DEF,
    parameter int LONG_TICKS   = BTN_LONG_TICKS_DEF,
    parameter int REPEAT_TICKS = BTN_REPEAT_TICKS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat
);

    localparam int SW = $clog2(STABLE_CNT + 1);
    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CNT - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(LONG_TICKS - 1);
    localparam logic [HW-1:0] HOLD_MAX    = HW'(LONG_TICKS);

    logic [1:0]    r_sync;
    logic          r_level;
    logic          r_level_d;
    logic [SW-1:0] r_stab;
    logic          r_press;
    logic          r_release;

    btn_state_e    r_state, w_state_nxt;
    logic [HW-1:0] r_hold, w_hold_nxt;
    logic          w_long;

    // Edge pulses come from a delayed copy of the level, so they land one clk after the toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync    <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_stab    <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_btn};
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
            r_release <= ~r_level & r_level_d;
            if (i_tick) begin
                if (r_sync[1] != r_level) begin
                    if (r_stab == STABLE_LAST) begin
                        r_level <= ~r_level;
                        r_stab  <= '0;
                    end else begin
                        r_stab <= r_stab + 1'b1;
                    end
                end else begin
                    r_stab <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_long      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_level) begin
                    w_state_nxt = HELD;
                    w_hold_nxt  = '0;
                end
            end
            HELD: begin
                if (!r_level) begin
                    w_state_nxt = IDLE;
                end else if (i_tick) begin
                    if (r_hold == HOLD_LAST) begin
                        w_state_nxt = LONG;
                        w_hold_nxt  = HOLD_MAX;
                        w_long      = 1'b1;
                    end else begin
                        w_hold_nxt = r_hold + 1'b1;
                    end
                end
            end
            LONG: begin
                if (!r_level) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef BTN_REPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);

    logic [RW-1:0] r_rep, w_rep_nxt;
    logic          w_repeat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rep <= '0;
        else     r_rep <= w_rep_nxt;
    end

    // Held at zero outside LONG so the first repeat is a full period after the long event.
    always_comb begin
        w_rep_nxt = r_rep;
        w_repeat  = 1'b0;
        if (r_state != LONG) begin
            w_rep_nxt = '0;
        end else if (i_tick) begin
            if (r_rep == REP_LAST) begin
                w_repeat  = 1'b1;
                w_rep_nxt = '0;
            end else begin
                w_rep_nxt = r_rep + 1'b1;
            end
        end
    end

    assign o_repeat = w_repeat;
`else
    assign o_repeat = 1'b0;
`endif

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = w_long;

endmodule

// File: rtl/btn_filter_array.sv
// Array of debounced button channels sharing one sample-tick divider.
// Define BTN_REPEAT_EN to enable auto-repeat pulses on o_repeat.
module btn_filter_array
    import btn_pkg::*;
#(
    parameter int N_CH         = BTN_N_CH_DEF,
    parameter int TICK_DIV     = BTN_TICK_DIV_DEF,
    parameter int STABLE_CNT   = BTN_STABLE_CNT_DEF,
    parameter int LONG_TICKS   = BTN_LONG_TICKS_DEF,
    parameter int REPEAT_TICKS = BTN_REPEAT_TICKS_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] i_btn,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_long,
    output logic [N_CH-1:0] o_repeat
);

    localparam int DW = $clog2(TICK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    logic [DW-1:0] r_div;
    logic          w_tick;

    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_div <= '0;
        else if (w_tick) r_div <= '0;
        else             r_div <= r_div + 1'b1;
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        btn_channel #(
            .STABLE_CNT  (STABLE_CNT),
            .LONG_TICKS  (LONG_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .i_tick   (w_tick),
            .i_btn    (i_btn[g]),
            .o_level  (o_level[g]),
            .o_press  (o_press[g]),
            .o_release(o_release[g]),
            .o_long   (o_long[g]),
            .o_repeat (o_repeat[g])
        );
    end

endmodule

// File: tb/tb_btn_filter_array.sv
// Directed bench for btn_filter_array with small divider and tick limits.
// Table of level vectors followed by hand sequences for long press, repeat and reset.
module tb_btn_filter_array;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] i_btn;
    logic [N-1:0] o_level, o_press, o_release, o_long, o_repeat;

    always #5 clk = ~clk;

    btn_filter_array #(
        .N_CH(N), .TICK_DIV(4), .STABLE_CNT(3), .LONG_TICKS(10), .REPEAT_TICKS(5)
    ) dut (
        .clk(clk), .rst(rst), .i_btn(i_btn),
        .o_level(o_level), .o_press(o_press), .o_release(o_release),
        .o_long(o_long), .o_repeat(o_repeat)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int n_press[N] = '{default: 0};
    int n_rel[N]   = '{default: 0};
    int n_long[N]  = '{default: 0};
    int n_rep[N]   = '{default: 0};
    logic arm = 1'b0;
    int   rep_first = -1;
    int   rep_last  = -1;
    logic saw_pair  = 1'b0;
    logic saw_rel2  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (o_press[i])   n_press[i] <= n_press[i] + 1;
            if (o_release[i]) n_rel[i]   <= n_rel[i] + 1;
            if (o_long[i])    n_long[i]  <= n_long[i] + 1;
            if (o_repeat[i])  n_rep[i]   <= n_rep[i] + 1;
        end
        if (!arm) begin
            rep_first <= -1;
            rep_last  <= -1;
            saw_pair  <= 1'b0;
            saw_rel2  <= 1'b0;
        end else begin
            if (o_repeat[0]) begin
                if (rep_first < 0) rep_first <= cyc;
                rep_last <= cyc;
            end
            if (o_press[3:2] == 2'b11)  saw_pair <= 1'b1;
            if (o_release == 4'b0100)   saw_rel2 <= 1'b1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int tot_press();
        int s = 0;
        for (int i = 0; i < N; i++) s += n_press[i];
        return s;
    endfunction

    function automatic int tot_rel();
        int s = 0;
        for (int i = 0; i < N; i++) s += n_rel[i];
        return s;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [N-1:0] btn;
        int           cycles;
        logic [N-1:0] exp_level;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [N-1:0] prev;
        int p0, r0, l0, rp0, R, L, F, k;
        logic found;

        tbl[0]  = '{4'b0001, 24, 4'b0001};
        tbl[1]  = '{4'b0011, 24, 4'b0011};
        tbl[2]  = '{4'b0110, 24, 4'b0110};
        tbl[3]  = '{4'b1111, 24, 4'b1111};
        tbl[4]  = '{4'b1000, 24, 4'b1000};
        tbl[5]  = '{4'b0000, 24, 4'b0000};
        tbl[6]  = '{4'b0001,  4, 4'b0000};
        tbl[7]  = '{4'b0000, 24, 4'b0000};
        tbl[8]  = '{4'b1010, 24, 4'b1010};
        tbl[9]  = '{4'b0101, 24, 4'b0101};
        tbl[10] = '{4'b0000, 24, 4'b0000};

        rst   = 1'b1;
        i_btn = '0;
        step(3);
        check("reset_outputs", int'({o_level, o_press, o_release, o_long, o_repeat}), 0);
        rst = 1'b0;

        prev = '0;
        for (int i = 0; i < 11; i++) begin
            p0 = tot_press();
            r0 = tot_rel();
            i_btn = tbl[i].btn;
            step(tbl[i].cycles);
            check($sformatf("tbl%0d_level", i), int'(o_level), int'(tbl[i].exp_level));
            check($sformatf("tbl%0d_press", i), tot_press() - p0,
                  $countones(tbl[i].exp_level & ~prev));
            check($sformatf("tbl%0d_release", i), tot_rel() - r0,
                  $countones(prev & ~tbl[i].exp_level));
            prev = tbl[i].exp_level;
        end

        // ch1 glitches: never three differing samples in a row
        p0 = n_press[1];
        r0 = n_rel[1];
        for (int i = 0; i < 5; i++) begin
            i_btn[1] = 1'b1;
            step(8);
            i_btn[1] = 1'b0;
            step(4);
        end
        step(24);
        check("glitch_level", int'(o_level[1]), 0);
        check("glitch_press", n_press[1] - p0, 0);
        check("glitch_release", n_rel[1] - r0, 0);

        // ch2/ch3 together, then ch2 alone released
        arm = 1'b1;
        i_btn[3:2] = 2'b11;
        step(30);
        check("pair_press_same_cycle", int'(saw_pair), 1);
        check("pair_level", int'(o_level), 4'b1100);
        i_btn[2] = 1'b0;
        step(30);
        check("ch2_release_only", int'(saw_rel2), 1);
        check("ch2_release_level", int'(o_level), 4'b1000);
        i_btn[3] = 1'b0;
        arm = 1'b0;
        step(30);

        // ch0 long press with repeat window
        arm = 1'b1;
        p0 = n_press[0]; r0 = n_rel[0]; l0 = n_long[0]; rp0 = n_rep[0];
        R = 0; L = 0; F = 0;
        i_btn[0] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 18 && !found; i++) begin
            @(negedge clk);
            if (o_level[0]) begin found = 1'b1; R = cyc; end
        end
        check("press_within_18", int'(found), 1);
        check("press_not_same_cycle", int'(o_press[0]), 0);
        @(negedge clk);
        check("press_next_cycle", int'(o_press[0]), 1);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (o_long[0]) begin found = 1'b1; L = cyc; end
        end
        check("long_seen", int'(found), 1);
        check("long_at_hold_tick10", L - R, 39);
        check("no_release_while_held", n_rel[0] - r0, 0);
        step(76);
        i_btn[0] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (!o_level[0]) begin found = 1'b1; F = cyc; end
        end
        check("level_fall_22_ticks_after_long", F - L, 89);
        step(24);
        check("ch0_press_count", n_press[0] - p0, 1);
        check("ch0_long_count", n_long[0] - l0, 1);
        check("ch0_release_count", n_rel[0] - r0, 1);
`ifdef BTN_REPEAT_EN
        check("repeat_count", n_rep[0] - rp0, 4);
        check("repeat_first_offset", rep_first - L, 20);
        check("repeat_span", rep_last - rep_first, 60);
`else
        check("repeat_count", n_rep[0] - rp0, 0);
`endif
        arm = 1'b0;
        step(8);

        // reset while ch0 is in LONG, button still held
        i_btn[0] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (o_long[0]) found = 1'b1;
        end
        check("rst_long_reached", int'(found), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_outputs", int'({o_level, o_press, o_release, o_long, o_repeat}), 0);
        step(1);
        check("rst_held_outputs", int'({o_level, o_press, o_release, o_long, o_repeat}), 0);
        step(2);
        rst = 1'b0;
        p0 = n_press[0];
        found = 1'b0;
        k = -1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (o_level[0]) begin found = 1'b1; k = i; end
        end
        check("rst_repress_delay", k, 12);
        step(2);
        check("rst_repress_pulse", n_press[0] - p0, 1);
        i_btn = '0;
        step(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
